program_loader: RTL

// - Upstream feeder of the single-cycle CPU's instruction-memory write port: takes a byte stream

---
 rtl/program_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Serial frame loader for the CPU instruction memory.
// Assembles LEN/{HI,LO}xN/CSUM frames into 16-bit writes and holds the CPU.
module program_loader #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        start_load,
    output logic [15:0] data_in,
    output logic [7:0]  inst_add,
    output logic        instruction_wenable,
    output logic        load_done,
    output logic        load_err,
    output logic [8:0]  words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [8:0]      wr_idx;
    logic [8:0]      words_left;
    logic [7:0]      hi_shadow;
    logic [7:0]      csum;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            data_in             <= '0;
            inst_add            <= '0;
            instruction_wenable <= 1'b0;
            load_done           <= 1'b0;
            load_err            <= 1'b0;
            words_loaded        <= '0;
            wr_idx              <= '0;
            words_left          <= '0;
            hi_shadow           <= '0;
            csum                <= '0;
            to_cnt              <= '0;
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start_load) begin
                        state               <= LEN;
                        instruction_wenable <= 1'b1;
                        load_done           <= 1'b0;
                        load_err            <= 1'b0;
                        words_loaded        <= '0;
                        wr_idx              <= '0;
                        csum                <= '0;
                        to_cnt              <= '0;
                    end
                end
                LEN, HI, LO, CSUM: begin
                    if (rx_valid) begin
                        to_cnt <= '0;
                        if (state != CSUM)
                            csum <= csum ^ rx_data;
                        unique case (state)
                            LEN: begin
                                // A zero length byte encodes a full 256-word image
                                words_left <= (rx_data == 8'd0) ? 9'd256
                                                                : {1'b0, rx_data};
                                state <= HI;
                            end
                            HI: begin
                                hi_shadow <= rx_data;
                                state     <= LO;
                            end
                            LO: begin
                                data_in      <= {hi_shadow, rx_data};
                                inst_add     <= wr_idx[7:0];
                                wr_idx       <= wr_idx + 9'd1;
                                words_loaded <= words_loaded + 9'd1;
                                words_left   <= words_left - 9'd1;
                                state        <= (words_left > 9'd1) ? HI : CSUM;
                            end
                            default: begin
                                if (rx_data == csum) begin
                                    state               <= DONE;
                                    instruction_wenable <= 1'b0;
                                    load_done           <= 1'b1;
                                end else begin
                                    state    <= ERR;
                                    load_err <= 1'b1;
                                end
                            end
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        state    <= ERR;
                        load_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
